// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types for the RC4 message datapath: message geometry, byte/message
// typedefs and the state encoding of ram_writer.
//
// Configuration macro: RAM_WRITER_VERIFY_EN
//   When defined, ram_writer gains two read-back states, and the state
//   encoding grows from 2 to 3 bits.
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int MSG_BYTES = 32;
  localparam int BYTE_W    = 8;

  typedef logic [7:0] byte_t;
  typedef byte_t      msg_t [MSG_BYTES-1:0];

`ifdef RAM_WRITER_VERIFY_EN
  typedef enum logic [2:0] {
    RW_IDLE,
    RW_WRITE,
    RW_INC,
    RW_DONE,
    RW_VADDR,
    RW_VCHK
  } ram_writer_state_t;
`else
  typedef enum logic [1:0] {
    RW_IDLE,
    RW_WRITE,
    RW_INC,
    RW_DONE
  } ram_writer_state_t;
`endif

endpackage : rc4_pkg

// File: rtl/ram_writer.sv
// -----------------------------------------------------------------------------
// ram_writer
// Copies a DEPTH-byte message array into a single-port RAM, one byte per
// location, in response to a start/done handshake from the control FSM.
// The array is snapshotted when start is accepted, so the caller may change
// data_in freely while a pass is running.
//
// Timing (defaults): start sampled at edge 0, byte n written during cycle
// 2n+1 (WRITE/INC alternate), done first high in cycle 2*DEPTH+1.
//
// Configuration macro: RAM_WRITER_VERIFY_EN
//   Defined   : after the last write every location is read back and compared
//               with the snapshot; mismatch is set on any difference and
//               stays set until reset or the next accepted start. done is
//               then first high in cycle 4*DEPTH+1.
//   Undefined : ram_q is ignored and mismatch is constant 0.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   pass request, accepted only in IDLE and DONE
//   data_in  in   DEPTH x DATA_W byte array to write
//   ram_q    in   RAM read data (verify build only)
//   address  out  RAM address
//   data     out  RAM write data (0 outside WRITE)
//   wren     out  RAM write enable, one cycle per byte
//   busy     out  pass in progress
//   done     out  pass complete, held until the next start
//   mismatch out  read-back error flag
// -----------------------------------------------------------------------------
module ram_writer
  import rc4_pkg::*;
#(
  parameter int DEPTH  = MSG_BYTES,
  parameter int DATA_W = BYTE_W,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in [DEPTH-1:0],
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  // One extra index bit so the counter can never wrap inside a pass.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  ram_writer_state_t state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              load;
  logic [DATA_W-1:0] buf_q [DEPTH-1:0];

`ifdef RAM_WRITER_VERIFY_EN
  logic mis_q, mis_d;
`else
  // ram_q is part of the fixed port list but has no reader in this build.
  logic unused_ram_q;
  assign unused_ram_q = ^ram_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
`ifdef RAM_WRITER_VERIFY_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      RW_IDLE, RW_DONE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = RW_WRITE;
`ifdef RAM_WRITER_VERIFY_EN
          mis_d   = 1'b0;
`endif
        end
      end
      RW_WRITE: begin
        state_d = RW_INC;
      end
      RW_INC: begin
        if (idx_q == LAST_IDX) begin
`ifdef RAM_WRITER_VERIFY_EN
          idx_d   = '0;
          state_d = RW_VADDR;
`else
          state_d = RW_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RW_WRITE;
        end
      end
`ifdef RAM_WRITER_VERIFY_EN
      // Address is presented here; the RAM returns it one cycle later.
      RW_VADDR: begin
        state_d = RW_VCHK;
      end
      RW_VCHK: begin
        if (ram_q != buf_q[idx_q[ADDR_W-1:0]]) begin
          mis_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = RW_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RW_VADDR;
        end
      end
`endif
      default: begin
        state_d = RW_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RW_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RAM_WRITER_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`endif

  // Message snapshot: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // ---------------------------------------------------------------------------
  assign address = idx_q[ADDR_W-1:0];
  assign wren    = (state_q == RW_WRITE);
  assign data    = (state_q == RW_WRITE) ? buf_q[idx_q[ADDR_W-1:0]] : '0;
  assign done    = (state_q == RW_DONE);
  assign busy    = (state_q != RW_IDLE) && (state_q != RW_DONE);

`ifdef RAM_WRITER_VERIFY_EN
  assign mismatch = mis_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule : ram_writer

// File: tb/tb_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_ram_writer
// Self-checking bench for ram_writer: drives passes with fixed and random
// messages against a behavioural RAM and a message-level reference model.
// Honours RAM_WRITER_VERIFY_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_ram_writer;
  import rc4_pkg::*;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

`ifdef RAM_WRITER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // Cycle in which done is first observed after a start at edge 0.
  localparam int DONE_CYC = VERIFY ? 4*DEPTH + 1 : 2*DEPTH + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] din [DEPTH-1:0];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren, busy, done, mismatch;

  ram_writer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (din),
    .ram_q    (ram_q),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle registered read; optional read
  // corruption of location 7.
  logic [DATA_W-1:0] mem [DEPTH];
  bit                corrupt7 = 1'b0;

  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    ram_q <= (corrupt7 && address == 5'd7) ? 8'h00 : mem[address];
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: message captured when the pass is requested.
  logic [DATA_W-1:0] snap [DEPTH-1:0];

  task automatic run_pass(input string tag, input int change_cyc, input bit hold_start);
    int got_a[$];
    int got_d[$];
    int first_done = 0;
    int busy_n = 0;
    int wide = 0;
    int bad_seq = 0;
    int bad_ram = 0;
    bit prev_w = 1'b0;
    bit exp_mis = 1'b0;

    @(negedge clk);
    start = 1'b1;
    snap  = din;
    for (int c = 1; c <= 4*DEPTH + 40; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (c == 1) chk({tag, "_mis_clear"}, mismatch, 0);
      if (c == change_cyc) foreach (din[i]) din[i] = 8'hFF;
      if (busy) busy_n++;
      if (wren) begin
        got_a.push_back(int'(address));
        got_d.push_back(int'(data));
        if (prev_w) wide++;
      end
      prev_w = wren;
      if (done) begin
        first_done = c;
        break;
      end
    end
    start = 1'b0;

    chk({tag, "_done_cycle"}, first_done, DONE_CYC);
    chk({tag, "_busy_cycles"}, busy_n, DONE_CYC - 1);
    chk({tag, "_n_writes"}, got_a.size(), DEPTH);
    chk({tag, "_wren_wide"}, wide, 0);
    for (int i = 0; i < got_a.size(); i++)
      if (got_a[i] != i || got_d[i] != int'(snap[i])) bad_seq++;
    chk({tag, "_write_seq"}, bad_seq, 0);
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== snap[i]) bad_ram++;
    chk({tag, "_ram_image"}, bad_ram, 0);
    if (VERIFY)
      for (int i = 0; i < DEPTH; i++)
        if (((corrupt7 && i == 7) ? 8'h00 : snap[i]) != snap[i]) exp_mis = 1'b1;
    chk({tag, "_mismatch"}, mismatch, exp_mis);
    @(negedge clk);
    chk({tag, "_done_hold"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    foreach (din[i]) din[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_wren", wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_address", address, 0);
    chk("rst_data", data, 0);
    chk("rst_mismatch", mismatch, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp message, input scribbled mid-pass.
    foreach (din[i]) din[i] = 8'h40 + 8'(i);
    run_pass("ramp", 10, 1'b0);

    // Start held for the whole pass, then restart from DONE.
    foreach (din[i]) din[i] = 8'h40 + 8'(i);
    run_pass("hold", 0, 1'b1);
    foreach (din[i]) din[i] = 8'hA5;
    run_pass("a5", 0, 1'b0);

    // Random message.
    foreach (din[i]) din[i] = 8'($urandom);
    run_pass("rand1", 0, 1'b0);

    // Corrupted read-back of location 7, then a clean pass.
    corrupt7 = 1'b1;
    foreach (din[i]) din[i] = 8'($urandom_range(1, 255));
    run_pass("corrupt", 0, 1'b0);
    corrupt7 = 1'b0;
    foreach (din[i]) din[i] = 8'($urandom);
    run_pass("clean", 0, 1'b0);

    // Asynchronous reset between edges in the middle of a pass.
    foreach (din[i]) din[i] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_wren", wren, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_wren", wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wren", wren, 0);

    foreach (din[i]) din[i] = 8'($urandom);
    run_pass("rand2", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_ram_writer

// File: doc/ram_writer.md
Name: ram_writer

Overview:
- Sequential writer that takes a 32-byte message array and writes it, one byte per location, into a single-port on-chip RAM (altsyncram style: address, data, wren).
- It is the write-side counterpart to the block that fills the byte array from ROM. It carries the decrypted/key-candidate message from the register array into the result RAM, where it can be inspected.
- Controlled by a start/done handshake from the top-level control FSM.

Parameters:
- DEPTH, 32, number of bytes written per pass, also the number of RAM locations covered
- DATA_W, 8, width of each byte / RAM word
- ADDR_W, 5, RAM address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk, input, 1, single system clock; all state changes on rising edge
- reset, input, 1, asynchronous active-high reset
- start, input, 1, level/pulse request; sampled in IDLE and DONE
- data_in, input, DATA_W x DEPTH (unpacked [DEPTH-1:0]), byte array to write; snapshotted when start is accepted
- ram_q, input, DATA_W, RAM read data; used only with the optional feature
- address, output, ADDR_W, RAM address
- data, output, DATA_W, RAM write data
- wren, output, 1, RAM write enable
- busy, output, 1, high from start acceptance until done
- done, output, 1, pass complete
- mismatch, output, 1, readback error flag (optional feature; 0 otherwise)

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state = IDLE; index = 0.
  - address = 0, data = 0, wren = 0, busy = 0, done = 0, mismatch = 0.
- States: IDLE, WRITE, INC, DONE; VERIFY_ADDR and VERIFY_CHECK exist only with the optional feature.
- IDLE:
  - When start = 1: snapshot data_in into the internal buffer, index = 0, go to WRITE.
  - Otherwise remain in IDLE.
- WRITE (one cycle): address = index, data = buf[index], wren = 1.
- INC (one cycle):
  - wren = 0.
  - If index == DEPTH-1, go to DONE; otherwise index += 1 and go to WRITE.
- DONE:
  - done = 1, busy = 0, wren = 0; hold here.
  - start = 1 re-snapshots data_in, clears done, and goes to WRITE with index = 0 (restart).
- busy = 1 in every state except IDLE and DONE.
- Latency: start sampled at edge 0 → WRITE of index n during cycle 2n+1 → done first high in cycle 2*DEPTH+1 (65 for defaults).
- Control is edge-based and registered: outputs are registered, or decoded from the registered state, with no combinational path from start.
- start while busy: ignored. The snapshot is stable, so changes to data_in mid-pass have no effect.
- Index counter:
  - Width is ADDR_W+1 bits, so it never wraps inside a pass.
  - address = index[ADDR_W-1:0].
- Reset mid-pass: immediate abort; wren drops asynchronously. The partial RAM contents are not defined by this block.

Optional Feature:
- Macro: RAM_WRITER_VERIFY_EN.
- Defined:
  - After the last INC, the block enters VERIFY_ADDR instead of DONE, with index = 0.
  - VERIFY_ADDR: address = index, wren = 0.
  - VERIFY_CHECK: address held; ram_q is compared with buf[index] (RAM read latency is 1 cycle after the registered address). On inequality, mismatch is set.
  - mismatch is sticky until reset or the next accepted start.
  - VERIFY_CHECK then goes to DONE if index == DEPTH-1, otherwise index += 1 and back to VERIFY_ADDR.
  - done is first high in cycle 4*DEPTH+1 (129 for defaults).
- Undefined:
  - The ram_q port is still present but ignored.
  - mismatch is tied to 0.
  - The verify states are not compiled.

Decomposition:
- Shared package rc4_pkg holds:
  - MSG_BYTES = 32, BYTE_W = 8
  - typedef logic [7:0] byte_t
  - typedef byte_t msg_t [MSG_BYTES-1:0]
  - the state enum ram_writer_state_t (2-bit; 3-bit with the verify feature)
- No sub-module is needed: a single FSM with an index counter. The buffer snapshot stays inline.

Test Plan:
- Reset, then start pulse with data_in[i] = i+8'h40 → 32 wren pulses, each one cycle wide, at addresses 0..31 with data 8'h40..8'h5F. done is high in cycle 65, busy is high in cycles 1..64.
- data_in changed to all 8'hFF at cycle 10 mid-pass → RAM model still holds 8'h40+i at every address.
- start held high throughout a pass → no restart mid-pass. In DONE, the next start re-runs with fresh data (all 8'hA5) → RAM = 8'hA5 everywhere, done is low for 64 cycles and then high again.
- reset asserted asynchronously at cycle 20 (between edges) → wren, busy and done are 0 before the next edge. The FSM is in IDLE and waits for start.
- RAM_WRITER_VERIFY_EN with a correct RAM model → mismatch = 0, done in cycle 129.
- RAM_WRITER_VERIFY_EN with the RAM model corrupting address 7 to 8'h00 → mismatch goes to 1 at the address-7 check and stays 1 through DONE. The next accepted start clears it.
